// File: rtl/add_serial_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : add_serial_seq_if
//  Purpose  : Bundles the operand stream, the adder control/data lines and
//             the result stream of the serial-adder sequencer.
//             'slave' is the sequencer's view; 'master' is the surrounding
//             environment (operand source, adder, result consumer).
//  Revision : 1.0  initial release
// ============================================================================
interface add_serial_seq_if #(
    parameter int WIDTH = 8
);
    // Operand stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_chain;

    // Adder interface
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_en;
    logic [WIDTH-1:0] add_out;

    // Result stream
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport slave (
        input  in_valid, in_a, in_b, in_chain, add_out, res_ready,
        output in_ready, add_a, add_b, add_en, res_valid, res_data
    );

    modport master (
        output in_valid, in_a, in_b, in_chain, add_out, res_ready,
        input  in_ready, add_a, add_b, add_en, res_valid, res_data
    );
endinterface
`default_nettype wire

// File: rtl/add_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module   : add_serial_seq
//  Purpose  : Upstream sequencer for the bit-serial adder. Accepts an operand
//             pair, launches the adder with a one-cycle enable, waits the
//             adder's fixed latency, presents the captured result, then
//             re-arms the adder (DONE->IDLE pulse) and idles for a short gap
//             before accepting the next pair. Chain mode substitutes the last
//             result for operand b.
//  Revision : 1.0  initial release
// ============================================================================
module add_serial_seq #(
    parameter int WIDTH     = 8,
    parameter int LAT       = 10,
    parameter int REARM_GAP = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,       // synchronous, active low
    add_serial_seq_if.slave   bus,
    output logic              busy,
    output logic [7:0]        op_count
);

    // A gap below one cycle cannot guarantee the adder has left DONE.
    localparam int c_gap     = (REARM_GAP < 1) ? 1 : REARM_GAP;
    localparam int c_lat     = (LAT < 1) ? 1 : LAT;
    localparam int c_cnt_max = (c_lat > c_gap) ? c_lat : c_gap;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    typedef logic [c_cnt_w-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_REARM  = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state_q,     w_state_d;
    cnt_t             r_cnt_q,       w_cnt_d;
    logic             r_in_ready_q,  w_in_ready_d;
    logic             r_busy_q,      w_busy_d;
    logic             r_add_en_q,    w_add_en_d;
    logic [WIDTH-1:0] r_add_a_q,     w_add_a_d;
    logic [WIDTH-1:0] r_add_b_q,     w_add_b_d;
    logic             r_res_valid_q, w_res_valid_d;
    logic [WIDTH-1:0] r_res_data_q,  w_res_data_d;
    logic [WIDTH-1:0] r_last_q,      w_last_d;
    logic [7:0]       r_op_count_q,  w_op_count_d;

    // Next-state and next-output computation for the whole sequencer
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_add_en_d    = r_add_en_q;
        w_add_a_d     = r_add_a_q;
        w_add_b_d     = r_add_b_q;
        w_res_valid_d = r_res_valid_q;
        w_res_data_d  = r_res_data_q;
        w_last_d      = r_last_q;
        w_op_count_d  = r_op_count_q;

        case (r_state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_add_a_d  = bus.in_a;
                    w_add_b_d  = bus.in_chain ? r_last_q : bus.in_b;
                    w_add_en_d = 1'b1;
                    w_state_d  = S_LAUNCH;
                end
            end

            // The edge ending this state is the one the adder samples en on;
            // the result is stable LAT edges later.
            S_LAUNCH: begin
                w_add_en_d = 1'b0;
                w_cnt_d    = cnt_t'(c_lat - 1);
                w_state_d  = S_WAIT;
            end

            S_WAIT: begin
                if (r_cnt_q == '0) begin
                    w_res_data_d  = bus.add_out;
                    w_last_d      = bus.add_out;
                    w_res_valid_d = 1'b1;
                    w_state_d     = S_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - cnt_t'(1);
                end
            end

            // Result held until the consumer takes it; the handshake edge
            // also raises the re-arm pulse.
            S_RESP: begin
                if (bus.res_ready) begin
                    w_res_valid_d = 1'b0;
                    w_op_count_d  = r_op_count_q + 8'd1;
                    w_add_en_d    = 1'b1;
                    w_state_d     = S_REARM;
                end
            end

            S_REARM: begin
                w_add_en_d = 1'b0;
                w_cnt_d    = cnt_t'(c_gap - 1);
                w_state_d  = S_GAP;
            end

            S_GAP: begin
                if (r_cnt_q == '0) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q - cnt_t'(1);
                end
            end

            default: begin
                w_add_en_d    = 1'b0;
                w_res_valid_d = 1'b0;
                w_state_d     = S_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they are
        // registered and aligned with it.
        w_in_ready_d = (w_state_d == S_IDLE);
        w_busy_d     = (w_state_d != S_IDLE);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_in_ready_q  <= 1'b1;
            r_busy_q      <= 1'b0;
            r_add_en_q    <= 1'b0;
            r_add_a_q     <= '0;
            r_add_b_q     <= '0;
            r_res_valid_q <= 1'b0;
            r_res_data_q  <= '0;
            r_last_q      <= '0;
            r_op_count_q  <= 8'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_in_ready_q  <= w_in_ready_d;
            r_busy_q      <= w_busy_d;
            r_add_en_q    <= w_add_en_d;
            r_add_a_q     <= w_add_a_d;
            r_add_b_q     <= w_add_b_d;
            r_res_valid_q <= w_res_valid_d;
            r_res_data_q  <= w_res_data_d;
            r_last_q      <= w_last_d;
            r_op_count_q  <= w_op_count_d;
        end
    end

    assign bus.in_ready  = r_in_ready_q;
    assign bus.add_a     = r_add_a_q;
    assign bus.add_b     = r_add_b_q;
    assign bus.add_en    = r_add_en_q;
    assign bus.res_valid = r_res_valid_q;
    assign bus.res_data  = r_res_data_q;
    assign busy          = r_busy_q;
    assign op_count      = r_op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_serial_seq
//  Purpose  : Directed, table-driven bench for add_serial_seq with a
//             behavioural serial-adder model (IDLE/CALC/DONE protocol).
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_serial_seq;

    localparam int LAT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;

    add_serial_seq_if #(.WIDTH(8)) bus ();

    add_serial_seq #(.WIDTH(8), .LAT(LAT), .REARM_GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Adder model: samples en in IDLE, output is the complement of the sum
    // until one edge before the result must be stable, then DONE; en in
    // DONE returns it to IDLE. en while computing is a protocol error.
    logic [1:0] m_st;
    logic [3:0] m_cnt;
    logic [7:0] m_sum;
    int         m_err = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_st        <= 2'd0;
            m_cnt       <= 4'd0;
            m_sum       <= 8'd0;
            bus.add_out <= 8'd0;
        end else begin
            case (m_st)
                2'd0: if (bus.add_en) begin
                    m_sum       <= 8'(bus.add_a + bus.add_b);
                    bus.add_out <= ~8'(bus.add_a + bus.add_b);
                    m_cnt       <= 4'(LAT - 1);
                    m_st        <= 2'd1;
                end
                2'd1: begin
                    if (bus.add_en) m_err <= m_err + 1;
                    m_cnt <= m_cnt - 4'd1;
                    if (m_cnt == 4'd1) begin
                        bus.add_out <= m_sum;
                        m_st        <= 2'd2;
                    end
                end
                default: if (bus.add_en) m_st <= 2'd0;
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Observations from the last transaction
    int         g_k_valid, g_k_rearm, g_k_ready;
    int         g_en_total, g_en_extra, g_en_launch, g_stab, g_busy_low, g_valid_rearm;
    logic [7:0] g_res, g_add_a, g_add_b, g_add_a_end;

    // One transaction. k counts sample points after the accept edge (k=0).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic chain,
                          input int hold, input logic keep_valid);
        int k;
        int hc;
        g_k_valid = -1; g_k_rearm = -1; g_k_ready = -1;
        g_en_total = 0; g_en_extra = 0; g_en_launch = 0; g_stab = 0;
        g_busy_low = 0; g_valid_rearm = 0; g_res = 8'h00;
        hc = 0;
        bus.in_a = a; bus.in_b = b; bus.in_chain = chain; bus.in_valid = 1'b1;
        bus.res_ready = (hold == 0);
        @(posedge clk); #1;
        if (keep_valid) begin
            bus.in_a = 8'hEE; bus.in_b = 8'hEE;
        end else begin
            bus.in_valid = 1'b0;
        end
        g_add_a = bus.add_a;
        g_add_b = bus.add_b;
        k = 0;
        while (k < 200) begin
            if (bus.in_ready && k > 0) begin
                g_k_ready = k;
                break;
            end
            if (!busy) g_busy_low++;
            if (bus.add_en) begin
                g_en_total++;
                if (k == 0) g_en_launch = 1;
                else if (g_k_valid < 0) g_en_extra++;
                else if (g_k_rearm < 0) begin
                    g_k_rearm = k;
                    g_valid_rearm = bus.res_valid;
                end
            end
            if (bus.res_valid && g_k_valid < 0) begin
                g_k_valid = k;
                g_res = bus.res_data;
            end
            if (g_k_valid >= 0 && bus.res_valid && bus.res_data !== g_res) g_stab++;
            if (g_k_valid >= 0 && g_k_rearm < 0) begin
                hc++;
                if (hc >= hold) bus.res_ready = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        g_add_a_end = bus.add_a;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        int         hold;
        logic       keep;
        logic [7:0] exp_b;
        logic [7:0] exp_res;
        logic [7:0] exp_ops;
    } vec_t;

    vec_t vt[8];

    initial begin
        int rearm_exp;
        vt[0] = '{8'h12, 8'h34, 1'b0,  0, 1'b0, 8'h34, 8'h46, 8'd1};
        vt[1] = '{8'hF0, 8'h20, 1'b0,  0, 1'b0, 8'h20, 8'h10, 8'd2};
        vt[2] = '{8'h05, 8'h07, 1'b0,  0, 1'b0, 8'h07, 8'h0C, 8'd3};
        vt[3] = '{8'h03, 8'hFF, 1'b1,  0, 1'b0, 8'h0C, 8'h0F, 8'd4};
        vt[4] = '{8'h80, 8'h01, 1'b0, 20, 1'b0, 8'h01, 8'h81, 8'd5};
        vt[5] = '{8'h11, 8'h22, 1'b0,  0, 1'b1, 8'h22, 8'h33, 8'd6};
        vt[6] = '{8'h01, 8'h01, 1'b1,  0, 1'b0, 8'h33, 8'h34, 8'd7};
        vt[7] = '{8'hFF, 8'hFF, 1'b0,  0, 1'b0, 8'hFF, 8'hFE, 8'd8};

        bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00;
        bus.in_chain = 1'b0; bus.res_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_busy",      int'(busy),          0);
        chk("rst_add_en",    int'(bus.add_en),    0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_data",  int'(bus.res_data),  0);
        chk("rst_add_a",     int'(bus.add_a),     0);
        chk("rst_op_count",  int'(op_count),      0);
        // res_ready outside RESP must not disturb anything
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready_ignored", int'(op_count), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].chain, vt[i].hold, vt[i].keep);
            rearm_exp = 11 + ((vt[i].hold > 1) ? vt[i].hold : 1);
            chk($sformatf("v%0d_add_a", i),      int'(g_add_a),     int'(vt[i].a));
            chk($sformatf("v%0d_add_a_hold", i), int'(g_add_a_end), int'(vt[i].a));
            chk($sformatf("v%0d_add_b", i),      int'(g_add_b),     int'(vt[i].exp_b));
            chk($sformatf("v%0d_res", i),        int'(g_res),       int'(vt[i].exp_res));
            chk($sformatf("v%0d_k_valid", i),    g_k_valid,         11);
            chk($sformatf("v%0d_k_rearm", i),    g_k_rearm,         rearm_exp);
            chk($sformatf("v%0d_k_ready", i),    g_k_ready,         rearm_exp + 2);
            chk($sformatf("v%0d_en_launch", i),  g_en_launch,       1);
            chk($sformatf("v%0d_en_extra", i),   g_en_extra,        0);
            chk($sformatf("v%0d_en_total", i),   g_en_total,        2);
            chk($sformatf("v%0d_res_stable", i), g_stab,            0);
            chk($sformatf("v%0d_busy", i),       g_busy_low,        0);
            chk($sformatf("v%0d_valid_drop", i), g_valid_rearm,     0);
            chk($sformatf("v%0d_op_count", i),   int'(op_count),    int'(vt[i].exp_ops));
        end

        // Reset while waiting on the adder
        bus.in_a = 8'h09; bus.in_b = 8'h09; bus.in_chain = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy",      int'(busy),          0);
        chk("midrst_res_valid", int'(bus.res_valid), 0);
        chk("midrst_add_en",    int'(bus.add_en),    0);
        chk("midrst_op_count",  int'(op_count),      0);
        chk("midrst_in_ready",  int'(bus.in_ready),  1);
        chk("midrst_add_a",     int'(bus.add_a),     0);
        rst = 1'b1;

        // Chain right after reset uses b=0
        run_op(8'h07, 8'h55, 1'b1, 0, 1'b0);
        chk("postrst_chain_b",   int'(g_add_b), 0);
        chk("postrst_chain_res", int'(g_res),   7);
        run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);
        chk("postrst_res",      int'(g_res),    2);
        chk("postrst_k_ready",  g_k_ready,      14);
        chk("postrst_op_count", int'(op_count), 2);

        // op_count wrap 255 -> 0
        for (int i = 0; i < 253; i++) run_op(8'(i), 8'h01, 1'b0, 0, 1'b0);
        chk("wrap_255", int'(op_count), 255);
        run_op(8'h20, 8'h02, 1'b0, 0, 1'b0);
        chk("wrap_0",     int'(op_count), 0);
        chk("wrap_res",   int'(g_res),    8'h22);

        chk("adder_protocol", m_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
